// File: rtl/fetch_buffer_stage_pkg.sv
// Fetch-stage local types: FSM state encoding and the default reset PC.
package fetch_buffer_stage_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0200;

endpackage

// File: rtl/rv32i_types_pkg.sv
// RV32I shared types: opcodes, instruction encodings and the fetch->execute pipeline entry.
package rv32i_types_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        ITYPE  = 7'b0010011,
        RTYPE  = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic       imm12;
        logic [5:0] imm10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm4_1;
        logic       imm11;
        opcode_t    opcode;
    } sbtype_t;

    typedef struct packed {
        logic       imm20;
        logic [9:0] imm10_1;
        logic       imm11;
        logic [7:0] imm19_12;
        logic [4:0] rd;
        opcode_t    opcode;
    } ujtype_t;

    typedef struct packed {
        logic        token;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [31:0] prediction;
    } fetch_ex_pipeline_reg_t;

endpackage

// File: rtl/fetch_buffer_stage_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and execute handshake.
interface fetch_buffer_stage_if;
    import rv32i_types_pkg::*;

    logic [31:0]            imem_addr;
    logic                   imem_ren;
    logic                   imem_busy;
    logic [31:0]            imem_rdata;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   ex_ready;
    logic                   fetch_valid;
    fetch_ex_pipeline_reg_t fetch_ex_reg;

    modport master (
        output imem_addr, imem_ren, fetch_valid, fetch_ex_reg,
        input  imem_busy, imem_rdata, redirect, redirect_pc, ex_ready
    );

    modport slave (
        input  imem_addr, imem_ren, fetch_valid, fetch_ex_reg,
        output imem_busy, imem_rdata, redirect, redirect_pc, ex_ready
    );
endinterface

// File: rtl/fetch_buffer_stage_fetch_queue.sv
// Power-of-two FIFO of pipeline entries; flush beats push, head reads as zero when empty.
module fetch_queue
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   gclk,
    input  logic                   grst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_ex_pipeline_reg_t push_data,
    output fetch_ex_pipeline_reg_t head,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count
);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    fetch_ex_pipeline_reg_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is masked while the queue is empty.
    always_ff @(posedge gclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fetch_buffer_stage.sv
// RV32I fetch stage: PC/request FSM feeding a small entry queue toward execute.
// Optional backward-taken/forward-not-taken prediction under `FETCH_BTFN_PREDICT_EN.
module fetch_buffer_stage
    import rv32i_types_pkg::*;
    import fetch_buffer_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH = 2,
    localparam int         CW          = $clog2(QUEUE_DEPTH)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    fetch_buffer_stage_if.master bus
);
    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, tgt, tgt_n, pc4, next_pc;
    logic         ren, complete, outstanding, pop, push, full_after;
    logic         q_full, q_empty;
    logic [CW:0]  q_count;
    fetch_ex_pipeline_reg_t entry, q_head;

    assign ren         = (state == REQ) || (state == DISCARD);
    assign complete    = ren && !bus.imem_busy;
    assign outstanding = ren && bus.imem_busy;
    assign pop         = !q_empty && bus.ex_ready;
    assign pc4         = pc + 32'd4;
    assign full_after  = pop ? q_full : (q_count == (CW+1)'(QUEUE_DEPTH - 1));

`ifdef FETCH_BTFN_PREDICT_EN
    sbtype_t sb;
    ujtype_t uj;
    assign sb = sbtype_t'(bus.imem_rdata);
    assign uj = ujtype_t'(bus.imem_rdata);
    always_comb begin
        next_pc = pc4;
        if (uj.opcode == JAL)
            next_pc = pc + {{11{uj.imm20}}, uj.imm20, uj.imm19_12, uj.imm11, uj.imm10_1, 1'b0};
        else if (sb.opcode == BRANCH && sb.imm12)
            next_pc = pc + {{19{sb.imm12}}, sb.imm12, sb.imm11, sb.imm10_5, sb.imm4_1, 1'b0};
    end
`else
    assign next_pc = pc4;
`endif

    always_comb begin
        entry = '{token: 1'b1, pc: pc, pc4: pc4, instr: bus.imem_rdata, prediction: next_pc};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            pc    <= RESET_PC;
            tgt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            tgt   <= tgt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        tgt_n   = tgt;
        push    = 1'b0;
        case (state)
            IDLE: state_n = REQ;
            REQ: if (complete) begin
                push = 1'b1;
                pc_n = next_pc;
                if (full_after) state_n = WAIT;
            end
            WAIT: if (!q_full || pop) state_n = REQ;
            DISCARD: if (complete) begin
                pc_n    = tgt;
                state_n = REQ;
            end
            default: state_n = IDLE;
        endcase
        // Redirect overrides everything; a still-pending read must drain first.
        if (bus.redirect) begin
            push = 1'b0;
            if (outstanding) begin
                tgt_n   = {bus.redirect_pc[31:2], 2'b00};
                pc_n    = pc;
                state_n = DISCARD;
            end else begin
                pc_n    = {bus.redirect_pc[31:2], 2'b00};
                state_n = REQ;
            end
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .gclk      (CLK),
        .grst_n    (nRST),
        .push      (push),
        .pop       (pop),
        .flush     (bus.redirect),
        .push_data (entry),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign bus.imem_ren     = ren;
    assign bus.imem_addr    = pc;
    assign bus.fetch_valid  = !q_empty;
    assign bus.fetch_ex_reg = q_head;
endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Directed bench for fetch_buffer_stage; memory returns addr^0x5A000000 unless an instruction is forced.
module tb_fetch_buffer_stage;
    import rv32i_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic force_en = 1'b0;
    logic [31:0] force_instr = '0;
    int checks = 0;
    int failures = 0;
    fetch_ex_pipeline_reg_t f;

    fetch_buffer_stage_if bus();

    fetch_buffer_stage #(.RESET_PC(32'h0000_0200), .QUEUE_DEPTH(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
    );

    always #5 CLK = ~CLK;

    assign bus.imem_rdata = force_en ? force_instr : (bus.imem_addr ^ 32'h5A00_0000);
    assign f = bus.fetch_ex_reg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic redir(input logic [31:0] target);
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        step();
        bus.redirect    = 1'b0;
    endtask

    initial begin
        bus.imem_busy   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.ex_ready    = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_valid", {31'b0, bus.fetch_valid}, 32'd0);
        chk("rst_ren",   {31'b0, bus.imem_ren}, 32'd0);
        chk("rst_head",  {31'b0, |bus.fetch_ex_reg}, 32'd0);
        nRST = 1'b1;
        chk("idle_ren",  {31'b0, bus.imem_ren}, 32'd0);
        step();
        chk("a0_addr",   bus.imem_addr, 32'h200);
        chk("a0_ren",    {31'b0, bus.imem_ren}, 32'd1);
        chk("a0_valid",  {31'b0, bus.fetch_valid}, 32'd0);
        step();
        chk("a1_addr",   bus.imem_addr, 32'h204);
        chk("e0_valid",  {31'b0, bus.fetch_valid}, 32'd1);
        chk("e0_tok",    {31'b0, f.token}, 32'd1);
        chk("e0_pc",     f.pc, 32'h200);
        chk("e0_pc4",    f.pc4, 32'h204);
        chk("e0_instr",  f.instr, 32'h5A00_0200);
        chk("e0_pred",   f.prediction, 32'h204);
        step();
        chk("a2_addr",   bus.imem_addr, 32'h208);
        chk("e1_pc4",    f.pc4, 32'h208);
        step();
        chk("e2_pc4",    f.pc4, 32'h20C);
        chk("e2_tok",    {31'b0, f.token}, 32'd1);

        // Back-pressure: queue fills to two entries then fetch stalls.
        bus.ex_ready = 1'b0;
        step();
        chk("bp_ren0",   {31'b0, bus.imem_ren}, 32'd0);
        chk("bp_head0",  f.pc, 32'h208);
        step();
        chk("bp_ren1",   {31'b0, bus.imem_ren}, 32'd0);
        chk("bp_hold",   f.pc, 32'h208);
        bus.ex_ready = 1'b1;
        step();
        chk("bp_ren2",   {31'b0, bus.imem_ren}, 32'd1);
        chk("bp_addr2",  bus.imem_addr, 32'h210);
        chk("bp_head1",  f.pc, 32'h20C);
        bus.ex_ready = 1'b0;
        step();
        chk("bp_ren3",   {31'b0, bus.imem_ren}, 32'd0);
        chk("bp_head2",  f.pc, 32'h20C);
        bus.ex_ready = 1'b1;
        step();
        chk("bp_head3",  f.pc, 32'h210);
        chk("bp_addr3",  bus.imem_addr, 32'h214);

        // Redirect while a request is stalled: data dropped, then new target.
        redir(32'h300);
        chk("r0_valid",  {31'b0, bus.fetch_valid}, 32'd0);
        chk("r0_addr",   bus.imem_addr, 32'h300);
        bus.imem_busy = 1'b1;
        step();
        redir(32'h1000);
        chk("d_ren",     {31'b0, bus.imem_ren}, 32'd1);
        chk("d_addr0",   bus.imem_addr, 32'h300);
        chk("d_valid0",  {31'b0, bus.fetch_valid}, 32'd0);
        step();
        chk("d_addr1",   bus.imem_addr, 32'h300);
        bus.imem_busy = 1'b0;
        step();
        chk("d_addr2",   bus.imem_addr, 32'h1000);
        chk("d_valid2",  {31'b0, bus.fetch_valid}, 32'd0);
        step();
        chk("d_head",    f.pc, 32'h1000);
        chk("d_addr3",   bus.imem_addr, 32'h1004);

        // Redirect colliding with a completion; misaligned target is forced aligned.
        redir(32'h2002);
        chk("c_valid",   {31'b0, bus.fetch_valid}, 32'd0);
        chk("c_addr",    bus.imem_addr, 32'h2000);
        step();
        chk("c_head",    f.pc, 32'h2000);
        chk("c_addr1",   bus.imem_addr, 32'h2004);

        // PC wrap at the top of the address space.
        redir(32'hFFFF_FFFC);
        chk("w_addr",    bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("w_pc",      f.pc, 32'hFFFF_FFFC);
        chk("w_pc4",     f.pc4, 32'h0);
        chk("w_addr1",   bus.imem_addr, 32'h0);

`ifdef FETCH_BTFN_PREDICT_EN
        force_en    = 1'b1;
        force_instr = 32'hFE00_08E3;   // beq x0,x0,-16
        redir(32'h400);
        chk("p_addr",    bus.imem_addr, 32'h400);
        step();
        chk("p_bpred",   f.prediction, 32'h3F0);
        chk("p_baddr",   bus.imem_addr, 32'h3F0);
        force_instr = 32'h0200_006F;   // jal x0,+0x20
        redir(32'h500);
        chk("p_jaddr0",  bus.imem_addr, 32'h500);
        step();
        chk("p_jpred",   f.prediction, 32'h520);
        chk("p_jaddr",   bus.imem_addr, 32'h520);
        force_en = 1'b0;
`endif

        // Reset asserted with a request outstanding abandons it.
        bus.imem_busy = 1'b1;
        step();
        nRST = 1'b0;
        #1;
        chk("mr_ren",    {31'b0, bus.imem_ren}, 32'd0);
        chk("mr_valid",  {31'b0, bus.fetch_valid}, 32'd0);
        chk("mr_head",   {31'b0, |bus.fetch_ex_reg}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        bus.imem_busy = 1'b0;
        step();
        chk("mr_addr",   bus.imem_addr, 32'h200);
        step();
        chk("mr_e0",     f.pc, 32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
